serial_magnitude_comparator: RTL and testbench
==============================================

// Module: serial_magnitude_comparator
// PURPOSE
//   Bit-serial W-bit unsigned magnitude comparator, upstream of the 1-bit compare cell.
//   - Accepts operand pair A,B over a valid/ready handshake.
//   - Feeds the cell one bit pair per cycle, MSB first.
//   - Registers the one-hot result AeqB/AgtB/AltB and holds it until the consumer accepts it.
// PARAMETERS
//   W          8   operand width in bits, W >= 1
//   EARLY_EXIT 1   1: finish on first unequal bit pair; 0: always scan all W bits
// PORTS
//   clk        in   1  single clock, all state updates on rising edge
//   rst        in   1  synchronous, active-high reset
//   in_valid   in   1  operand pair A,B valid
//   in_ready   out  1  block can accept an operand pair
//   A          in   W  operand A, unsigned
//   B          in   W  operand B, unsigned
//   out_valid  out  1  result valid
//   out_ready  in   1  consumer accepts result
//   AeqB       out  1  A == B
//   AgtB       out  1  A > B
//   AltB       out  1  A < B
// BEHAVIOUR
//   Reset: state=IDLE; in_ready=1; out_valid=0; AeqB=AgtB=AltB=0; shift registers and count=0.
//   Reset mid-operation: the in-flight compare is discarded with no result. Next cycle is IDLE.
//   FSM states: IDLE, SHIFT, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
//   IDLE -> SHIFT when in_valid & in_ready at an edge:
//     - latch a_sh<=A, b_sh<=B, cnt<=W-1.
//   SHIFT, each cycle the cell compares a_sh[W-1] vs b_sh[W-1]:
//     - unequal & EARLY_EXIT=1: register AgtB/AltB from the cell, clear AeqB, go DONE.
//     - unequal & EARLY_EXIT=0: latch first-difference result in a sticky flag; later bits ignored.
//     - cnt==0: register the sticky result, or AeqB=1 if no difference was seen; go DONE.
//     - otherwise: shift a_sh/b_sh left by 1, cnt<=cnt-1.
//   DONE: outputs held stable while out_ready=0 (unbounded backpressure).
//     - out_valid & out_ready -> IDLE.
//     - result flags clear to 0 on that same edge.
//   Latency, acceptance edge to out_valid:
//     - full scan: W cycles.
//     - early exit at bit position p (MSB=W-1): W-p cycles.
//   W=1: a single SHIFT cycle, latency 1.
//   Exactly one result flag is high whenever out_valid=1; all three are 0 otherwise.
//   in_valid while busy (SHIFT/DONE): not accepted. Upstream must hold A,B until in_ready.
//   A,B are sampled only at acceptance; later changes have no effect on the in-flight compare.
//   No same-cycle turnaround: a new pair is accepted one cycle after the DONE->IDLE transition.
//   cnt width: $clog2(W), minimum 1. Decrements only; no wrap can occur.
// STRUCTURE
//   Shared package comparator_pkg:
//     - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
//     - result index constants RES_EQ/RES_GT/RES_LT.
//   Sub-module: one instance of the existing 1-bit Comparator cell on (a_sh[W-1], b_sh[W-1]).
//   Everything else (FSM, counter, shift registers, sticky flag, output registers) is inline.
// TESTING
//   1 W=8: A=8'hA5,B=8'hA5 accepted -> out_valid 8 cycles later, AeqB=1, AgtB=AltB=0.
//   2 W=8, EARLY_EXIT=1: A=8'h80,B=8'h7F -> AgtB=1 after 1 cycle.
//     Same with EARLY_EXIT=0 -> AgtB=1 after 8 cycles.
//   3 W=8: A=8'h12,B=8'h13 -> AltB=1 after 8 cycles.
//     A=8'hFF,B=8'h00 -> AgtB=1, latency 1 (early) or 8 (full).
//   4 Backpressure: out_ready=0 for 5 cycles in DONE -> flags and out_valid stable, in_ready=0.
//     in_valid pulses in that window are ignored. out_ready=1 -> IDLE next cycle, flags 0.
//   5 Reset: assert rst at cycle 3 of SHIFT -> next cycle in_ready=1, out_valid=0, flags 0.
//     A new pair 8'h01/8'h02 then completes normally with AltB=1.
//   6 W=1: (0,1)->AltB, (1,0)->AgtB, (1,1)->AeqB, each with latency 1.
//     Random back-to-back pairs checked against a reference compare model.

Source files
------------

// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared encodings for the bit-serial magnitude comparator.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package comparator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit positions of the one-hot result vector.
    localparam int RES_EQ = 0;
    localparam int RES_GT = 1;
    localparam int RES_LT = 2;
    localparam int RES_W  = 3;

    // Width of the bit counter; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Operand/result handshake bundle for the serial magnitude comparator.
// Latency: none (wires only).
// Backpressure: valid/ready on both the operand and result sides.
interface serial_magnitude_comparator_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic         AeqB;
    logic         AgtB;
    logic         AltB;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, AeqB, AgtB, AltB
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, AeqB, AgtB, AltB
    );
endinterface

// File: rtl/serial_magnitude_comparator_cell.sv
// 1-bit compare cell: classifies one bit pair as equal, greater or less.
// Latency: combinational.
// Backpressure: none.
module comparator_cell (
    input  logic a,
    input  logic b,
    output logic eq,
    output logic gt,
    output logic lt
);
    // Exactly one of the three outputs is high for any input pair.
    always_comb begin
        eq = ~(a ^ b);
        gt = a & ~b;
        lt = ~a & b;
    end
endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator, MSB first, one bit pair per cycle.
// Latency: W cycles from acceptance (W-p on early exit at differing bit p).
// Backpressure: result held in DONE until out_ready; no new operands accepted until IDLE.
module serial_magnitude_comparator
    import comparator_pkg::*;
#(
    parameter int W          = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    serial_magnitude_comparator_if.slave  bus
);

    localparam int CW = cnt_width(W);

    state_t             state_q, state_d;
    logic [W-1:0]       a_sh_q, a_sh_d;
    logic [W-1:0]       b_sh_q, b_sh_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               diff_seen_q, diff_seen_d;
    logic               diff_gt_q, diff_gt_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic               cell_eq;
    logic               cell_gt;
    logic               cell_lt;

    comparator_cell u_cell (
        .a  (a_sh_q[W-1]),
        .b  (b_sh_q[W-1]),
        .eq (cell_eq),
        .gt (cell_gt),
        .lt (cell_lt)
    );

    // Next-state logic: operand capture, serial scan, result hold and release.
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        cnt_d       = cnt_q;
        diff_seen_d = diff_seen_q;
        diff_gt_d   = diff_gt_q;
        res_d       = res_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_sh_d      = bus.A;
                    b_sh_d      = bus.B;
                    cnt_d       = CW'(W - 1);
                    diff_seen_d = 1'b0;
                    diff_gt_d   = 1'b0;
                    in_ready_d  = 1'b0;
                    state_d     = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (EARLY_EXIT && !cell_eq) begin
                    // First differing bit decides the whole compare.
                    res_d         = '0;
                    res_d[RES_GT] = cell_gt;
                    res_d[RES_LT] = cell_lt;
                    out_valid_d   = 1'b1;
                    state_d       = ST_DONE;
                end else if (cnt_q == '0) begin
                    // Last bit: an earlier difference wins over this one.
                    res_d = '0;
                    if (diff_seen_q) begin
                        res_d[RES_GT] = diff_gt_q;
                        res_d[RES_LT] = ~diff_gt_q;
                    end else if (!cell_eq) begin
                        res_d[RES_GT] = cell_gt;
                        res_d[RES_LT] = cell_lt;
                    end else begin
                        res_d[RES_EQ] = 1'b1;
                    end
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    // Full-scan mode remembers only the most significant difference.
                    if (!cell_eq && !diff_seen_q) begin
                        diff_seen_d = 1'b1;
                        diff_gt_d   = cell_gt;
                    end
                    a_sh_d = a_sh_q << 1;
                    b_sh_d = b_sh_q << 1;
                    cnt_d  = cnt_q - CW'(1);
                end
            end

            ST_DONE: begin
                if (bus.out_ready) begin
                    res_d       = '0;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                res_d       = '0;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any compare in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            cnt_q       <= '0;
            diff_seen_q <= 1'b0;
            diff_gt_q   <= 1'b0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            cnt_q       <= cnt_d;
            diff_seen_q <= diff_seen_d;
            diff_gt_q   <= diff_gt_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.AeqB      = res_q[RES_EQ];
    assign bus.AgtB      = res_q[RES_GT];
    assign bus.AltB      = res_q[RES_LT];

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed and randomised checks of three comparator variants (W=8 early, W=8 full, W=1).
// Latency: measured per compare from acceptance edge to out_valid.
// Backpressure: exercised by holding out_ready low in DONE.
module tb_serial_magnitude_comparator;

    logic clk;
    logic rst;

    int checks;
    int failures;

    // Selected DUT: 0 = W8 early exit, 1 = W8 full scan, 2 = W1.
    int         sel;
    logic       drv_valid;
    logic [7:0] drv_a;
    logic [7:0] drv_b;
    logic       drv_ordy;

    logic       obs_irdy;
    logic       obs_ovld;
    logic [2:0] obs_fl;

    localparam logic [2:0] F_EQ = 3'b001;
    localparam logic [2:0] F_GT = 3'b010;
    localparam logic [2:0] F_LT = 3'b100;

    serial_magnitude_comparator_if #(.W(8)) if_e ();
    serial_magnitude_comparator_if #(.W(8)) if_f ();
    serial_magnitude_comparator_if #(.W(1)) if_1 ();

    serial_magnitude_comparator #(.W(8), .EARLY_EXIT(1'b1)) dut_e (.clk(clk), .rst(rst), .bus(if_e));
    serial_magnitude_comparator #(.W(8), .EARLY_EXIT(1'b0)) dut_f (.clk(clk), .rst(rst), .bus(if_f));
    serial_magnitude_comparator #(.W(1), .EARLY_EXIT(1'b1)) dut_1 (.clk(clk), .rst(rst), .bus(if_1));

    assign if_e.in_valid  = drv_valid & (sel == 0);
    assign if_f.in_valid  = drv_valid & (sel == 1);
    assign if_1.in_valid  = drv_valid & (sel == 2);
    assign if_e.out_ready = drv_ordy & (sel == 0);
    assign if_f.out_ready = drv_ordy & (sel == 1);
    assign if_1.out_ready = drv_ordy & (sel == 2);
    assign if_e.A = drv_a;
    assign if_e.B = drv_b;
    assign if_f.A = drv_a;
    assign if_f.B = drv_b;
    assign if_1.A = drv_a[0];
    assign if_1.B = drv_b[0];

    assign obs_irdy = (sel == 0) ? if_e.in_ready  : (sel == 1) ? if_f.in_ready  : if_1.in_ready;
    assign obs_ovld = (sel == 0) ? if_e.out_valid : (sel == 1) ? if_f.out_valid : if_1.out_valid;
    assign obs_fl   = (sel == 0) ? {if_e.AltB, if_e.AgtB, if_e.AeqB} :
                      (sel == 1) ? {if_f.AltB, if_f.AgtB, if_f.AeqB} :
                                   {if_1.AltB, if_1.AgtB, if_1.AeqB};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a pair once the selected DUT is idle, then scramble A/B after acceptance.
    task automatic start_op(input int s, input logic [7:0] a, input logic [7:0] b);
        int g;
        sel = s;
        g = 0;
        while (!obs_irdy && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        drv_a = a;
        drv_b = b;
        drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        drv_a = ~a;
        drv_b = ~b;
    endtask

    task automatic wait_result(output int lat, output logic [2:0] fl);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!obs_ovld && lat < 100);
        fl = obs_fl;
    endtask

    task automatic release_op();
        drv_ordy = 1'b1;
        @(posedge clk); #1;
        drv_ordy = 1'b0;
    endtask

    task automatic do_op(input int s, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output logic [2:0] fl);
        start_op(s, a, b);
        wait_result(lat, fl);
        release_op();
    endtask

    function automatic int model_lat(input logic [7:0] a, input logic [7:0] b, input bit early);
        logic [7:0] x;
        x = a ^ b;
        if (!early || x == 8'h00) return 8;
        for (int i = 7; i >= 0; i--) if (x[i]) return 8 - i;
        return 8;
    endfunction

    function automatic logic [2:0] model_fl(input logic [7:0] a, input logic [7:0] b);
        if (a > b) return F_GT;
        if (a < b) return F_LT;
        return F_EQ;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if (obs_irdy !== 1'b1 || obs_ovld !== 1'b0 || obs_fl !== 3'b000) begin
                failures++;
                $display("FAIL reset_state dut=%0d irdy=%b ovld=%b flags=%b want 1 0 000",
                         s, obs_irdy, obs_ovld, obs_fl);
            end
        end
    endtask

    task automatic test_equal();
        int lat;
        logic [2:0] fl;
        for (int s = 0; s < 2; s++) begin
            do_op(s, 8'hA5, 8'hA5, lat, fl);
            checks++;
            if (lat !== 8 || fl !== F_EQ) begin
                failures++;
                $display("FAIL equal_a5 dut=%0d lat=%0d flags=%b want 8 %b", s, lat, fl, F_EQ);
            end
            checks++;
            if (obs_irdy !== 1'b1 || obs_ovld !== 1'b0 || obs_fl !== 3'b000) begin
                failures++;
                $display("FAIL release_clear dut=%0d irdy=%b ovld=%b flags=%b want 1 0 000",
                         s, obs_irdy, obs_ovld, obs_fl);
            end
        end
    endtask

    task automatic test_early_exit();
        int lat;
        logic [2:0] fl;
        do_op(0, 8'h80, 8'h7F, lat, fl);
        checks++;
        if (lat !== 1 || fl !== F_GT) begin
            failures++;
            $display("FAIL early_80_7f lat=%0d flags=%b want 1 %b", lat, fl, F_GT);
        end
        do_op(1, 8'h80, 8'h7F, lat, fl);
        checks++;
        if (lat !== 8 || fl !== F_GT) begin
            failures++;
            $display("FAIL full_80_7f lat=%0d flags=%b want 8 %b", lat, fl, F_GT);
        end
        // Later bits favour B; the first difference must still decide.
        do_op(1, 8'h40, 8'h3F, lat, fl);
        checks++;
        if (lat !== 8 || fl !== F_GT) begin
            failures++;
            $display("FAIL full_sticky_40_3f lat=%0d flags=%b want 8 %b", lat, fl, F_GT);
        end
        do_op(0, 8'h40, 8'h3F, lat, fl);
        checks++;
        if (lat !== 2 || fl !== F_GT) begin
            failures++;
            $display("FAIL early_40_3f lat=%0d flags=%b want 2 %b", lat, fl, F_GT);
        end
    endtask

    task automatic test_less_greater();
        int lat;
        logic [2:0] fl;
        for (int s = 0; s < 2; s++) begin
            do_op(s, 8'h12, 8'h13, lat, fl);
            checks++;
            if (lat !== 8 || fl !== F_LT) begin
                failures++;
                $display("FAIL less_12_13 dut=%0d lat=%0d flags=%b want 8 %b", s, lat, fl, F_LT);
            end
            do_op(s, 8'hFF, 8'h00, lat, fl);
            checks++;
            if (lat !== (s == 0 ? 1 : 8) || fl !== F_GT) begin
                failures++;
                $display("FAIL greater_ff_00 dut=%0d lat=%0d flags=%b want %0d %b",
                         s, lat, fl, (s == 0 ? 1 : 8), F_GT);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [2:0] fl;
        int bad;
        start_op(0, 8'hFF, 8'h00);
        wait_result(lat, fl);
        checks++;
        if (lat !== 1 || fl !== F_GT) begin
            failures++;
            $display("FAIL bp_result lat=%0d flags=%b want 1 %b", lat, fl, F_GT);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            drv_valid = i[0];
            drv_a = 8'h00;
            drv_b = 8'hFF;
            @(posedge clk); #1;
            if (obs_ovld !== 1'b1 || obs_fl !== F_GT || obs_irdy !== 1'b0) bad++;
        end
        drv_valid = 1'b0;
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL bp_hold unstable_cycles=%0d want 0", bad);
        end
        release_op();
        checks++;
        if (obs_ovld !== 1'b0 || obs_irdy !== 1'b1 || obs_fl !== 3'b000) begin
            failures++;
            $display("FAIL bp_release ovld=%b irdy=%b flags=%b want 0 1 000", obs_ovld, obs_irdy, obs_fl);
        end
        @(posedge clk); #1;
        checks++;
        if (obs_irdy !== 1'b1 || obs_ovld !== 1'b0) begin
            failures++;
            $display("FAIL bp_ignored_pulses irdy=%b ovld=%b want 1 0", obs_irdy, obs_ovld);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        logic [2:0] fl;
        start_op(1, 8'hA5, 8'hA5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (obs_irdy !== 1'b1 || obs_ovld !== 1'b0 || obs_fl !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid irdy=%b ovld=%b flags=%b want 1 0 000", obs_irdy, obs_ovld, obs_fl);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (obs_ovld) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL reset_discard result_cycles=%0d want 0", seen);
        end
        do_op(1, 8'h01, 8'h02, lat, fl);
        checks++;
        if (lat !== 8 || fl !== F_LT) begin
            failures++;
            $display("FAIL after_reset_01_02 lat=%0d flags=%b want 8 %b", lat, fl, F_LT);
        end
        do_op(0, 8'h01, 8'h02, lat, fl);
        checks++;
        if (lat !== 7 || fl !== F_LT) begin
            failures++;
            $display("FAIL after_reset_early_01_02 lat=%0d flags=%b want 7 %b", lat, fl, F_LT);
        end
    endtask

    task automatic test_w1();
        int lat;
        logic [2:0] fl;
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [2:0] ve [3];
        va[0] = 8'h00; vb[0] = 8'h01; ve[0] = F_LT;
        va[1] = 8'h01; vb[1] = 8'h00; ve[1] = F_GT;
        va[2] = 8'h01; vb[2] = 8'h01; ve[2] = F_EQ;
        for (int i = 0; i < 3; i++) begin
            do_op(2, va[i], vb[i], lat, fl);
            checks++;
            if (lat !== 1 || fl !== ve[i]) begin
                failures++;
                $display("FAIL w1_vec%0d lat=%0d flags=%b want 1 %b", i, lat, fl, ve[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [2:0] fl;
        logic [7:0] a;
        logic [7:0] b;
        int bad;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom_range(0, 255));
            b = (i % 4 == 0) ? a : 8'($urandom_range(0, 255));
            do_op(i % 2, a, b, lat, fl);
            if (lat !== model_lat(a, b, (i % 2) == 0) || fl !== model_fl(a, b)) begin
                bad++;
                $display("FAIL b2b dut=%0d a=%h b=%h lat=%0d flags=%b want %0d %b",
                         i % 2, a, b, lat, fl, model_lat(a, b, (i % 2) == 0), model_fl(a, b));
            end
        end
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom_range(0, 1));
            b = 8'($urandom_range(0, 1));
            do_op(2, a, b, lat, fl);
            if (lat !== 1 || fl !== model_fl(a, b)) begin
                bad++;
                $display("FAIL b2b_w1 a=%0d b=%0d lat=%0d flags=%b want 1 %b", a, b, lat, fl, model_fl(a, b));
            end
        end
        checks++;
        if (bad !== 0) failures++;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        sel       = 0;
        rst       = 1'b1;
        drv_valid = 1'b0;
        drv_a     = 8'h00;
        drv_b     = 8'h00;
        drv_ordy  = 1'b0;

        test_reset();
        test_equal();
        test_early_exit();
        test_less_greater();
        test_backpressure();
        test_reset_mid();
        test_w1();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
